// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: ROM read port, redirect request and instruction handshake.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  // Fetch unit side
  modport master (
    output rom_en, rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, jump, jump_addr, instr_ready
  );

  // ROM / execute / decode side
  modport slave (
    input  rom_en, rom_addr, instr, instr_pc, instr_valid,
    output rom_data, jump, jump_addr, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC-driven ROM reads, prefetch FIFO, valid/ready delivery, jump flush.
module instruction_fetch #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  instruction_fetch_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  entry_t            mem_q [DEPTH];
  entry_t            head_q, head_d;
  logic              valid_q, valid_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occ;
  logic [CNT_W-1:0]  remain;
  entry_t            wr_entry;

  // Handshake, issue decision and return-path write
  always_comb begin
    pop      = valid_q & bus.instr_ready;
    occ      = OCC_W'(cnt_q) + OCC_W'(infl_q) - OCC_W'(pop);
    issue    = reset_n & ~bus.jump & (occ < OCC_W'(DEPTH));
    push     = infl_q & ~bus.jump;
    remain   = cnt_q - CNT_W'(pop);
    wr_entry = '{word: bus.rom_data, pc: infl_pc_q};
  end

  // Next-state for PC, in-flight tracking, FIFO pointers and head outputs
  always_comb begin
    fpc_d     = fpc_q;
    infl_d    = issue;
    infl_pc_d = infl_pc_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    head_d    = head_q;
    valid_d   = valid_q;

    if (issue) begin
      fpc_d     = fpc_q + ADDR_W'(1);
      infl_pc_d = fpc_q;
    end

    if (bus.jump) begin
      // Redirect drops everything buffered and the word returning this cycle
      fpc_d    = bus.jump_addr;
      infl_d   = 1'b0;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      valid_d  = 1'b0;
    end else begin
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      valid_d  = (cnt_d != '0);
      // Next head is the oldest surviving entry, else the word arriving now
      if (remain != '0) begin
        head_d = mem_q[rd_ptr_d];
      end else if (push) begin
        head_d = wr_entry;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_q     <= '0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      head_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      head_q    <= head_d;
      valid_q   <= valid_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign bus.rom_en      = issue;
  assign bus.rom_addr    = fpc_q;
  assign bus.instr       = head_q.word;
  assign bus.instr_pc    = head_q.pc;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: ROM model plus a queue-of-fetched-words reference.
module tb_instruction_fetch;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    int                rdy;
  } fetch_t;

  logic clk;
  logic reset_n;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Words issued since the last flush, oldest first, with the cycle they become visible
  fetch_t            fq[$];
  logic [ADDR_W-1:0] exp_fpc;
  logic [ADDR_W-1:0] last_pc;
  logic [DATA_W-1:0] last_w;
  int                cyc;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(32'h1000 + 32'(a));
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: data one cycle after a strobed address, garbage otherwise
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);
    else            bus.rom_data <= DATA_W'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    exp_fpc = '0;
    last_pc = '0;
    last_w  = '0;
    cyc     = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_en"},      32'(bus.rom_en),      32'd0);
    chk({tag, "_rom_addr"},    32'(bus.rom_addr),    32'd0);
    chk({tag, "_instr"},       32'(bus.instr),       32'd0);
    chk({tag, "_instr_pc"},    32'(bus.instr_pc),    32'd0);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the reference
  task automatic cycle(input logic j, input logic [ADDR_W-1:0] ja, input logic rdy);
    logic vld_e, pop_e, en_e;
    int   occ;
    bus.jump        = j;
    bus.jump_addr   = ja;
    bus.instr_ready = rdy;
    @(negedge clk);
    vld_e = (fq.size() != 0) && (fq[0].rdy <= cyc);
    pop_e = vld_e && rdy;
    occ   = fq.size() - (pop_e ? 1 : 0);
    en_e  = !j && (occ < int'(DEPTH));
    chk("instr_valid", 32'(bus.instr_valid), 32'(vld_e));
    chk("rom_en", 32'(bus.rom_en), 32'(en_e));
    if (en_e) chk("rom_addr", 32'(bus.rom_addr), 32'(exp_fpc));
    if (vld_e) begin
      chk("instr_pc", 32'(bus.instr_pc), 32'(fq[0].pc));
      chk("instr", 32'(bus.instr), 32'(rom_word(fq[0].pc)));
      last_pc = fq[0].pc;
      last_w  = rom_word(fq[0].pc);
    end else begin
      chk("instr_pc_hold", 32'(bus.instr_pc), 32'(last_pc));
      chk("instr_hold", 32'(bus.instr), 32'(last_w));
    end
    if (pop_e) void'(fq.pop_front());
    if (j) begin
      fq.delete();
      exp_fpc = ja;
    end else if (en_e) begin
      fq.push_back('{pc: exp_fpc, rdy: cyc + 2});
      exp_fpc = exp_fpc + ADDR_W'(1);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic             rj;
    logic             rr;
    logic [ADDR_W-1:0] ra;

    reset_n         = 1'b1;
    bus.jump        = 1'b0;
    bus.jump_addr   = '0;
    bus.instr_ready = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #2 chk_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Start-up stream: pc 0,1,2 consumed, then stall on pc 3 for 5 cycles
    repeat (5) cycle(1'b0, '0, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1);

    // Jump while the prefetch buffer is full
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 15'h0040, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b1);

    // Wrap of the fetch PC
    cycle(1'b1, 15'h7FFE, 1'b1);
    repeat (7) cycle(1'b0, '0, 1'b1);

    // Back-to-back jumps: only the second target is delivered
    cycle(1'b1, 15'h0010, 1'b1);
    cycle(1'b1, 15'h0020, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Random consumer stalls and redirects
    for (int i = 0; i < 400; i++) begin
      rj = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 3) == 0) ? ADDR_W'(15'h7FFC + 15'($urandom_range(0, 3)))
                                       : ADDR_W'($urandom);
      cycle(rj, ra, rr);
    end

    // Asynchronous reset mid-stream with buffered words
    repeat (2) cycle(1'b0, '0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0);
    chk("pre_reset_valid", 32'(bus.instr_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1 chk_all_zero("reset_hold");
    reset_n = 1'b1;
    repeat (8) cycle(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
